// File: rtl/m_unit_ctrl_if.sv
// ============================================================================
// Module : m_unit_ctrl_pkg / m_unit_ctrl_if
// Brief  : Shared constants and request/datapath/response bundle of the M-unit controller
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m_unit_ctrl_pkg;
  localparam int XLEN = 64;
  localparam logic [5:0] ALU_OP_MUL    = 6'h20;
  localparam logic [5:0] ALU_OP_MULH   = 6'h21;
  localparam logic [5:0] ALU_OP_MULHSU = 6'h22;
  localparam logic [5:0] ALU_OP_MULHU  = 6'h23;
  localparam logic [5:0] ALU_OP_MULW   = 6'h24;
  localparam logic [5:0] ALU_OP_DIV    = 6'h28;
  localparam logic [5:0] ALU_OP_DIVU   = 6'h29;
  localparam logic [5:0] ALU_OP_REM    = 6'h2A;
  localparam logic [5:0] ALU_OP_REMU   = 6'h2B;
  localparam logic [5:0] ALU_OP_DIVW   = 6'h2C;
  localparam logic [5:0] ALU_OP_DIVUW  = 6'h2D;
  localparam logic [5:0] ALU_OP_REMW   = 6'h2E;
  localparam logic [5:0] ALU_OP_REMUW  = 6'h2F;
endpackage

interface m_unit_ctrl_if #(parameter int TAG_W = 5);
  import m_unit_ctrl_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [5:0]       req_op_i;
  logic [XLEN-1:0]  req_a_i;
  logic [XLEN-1:0]  req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic [5:0]       dp_op_o;
  logic [XLEN-1:0]  dp_a_o;
  logic [XLEN-1:0]  dp_b_o;
  logic             dp_start_o;
  logic             dp_abort_o;
  logic             dp_done_i;
  logic [XLEN-1:0]  dp_result_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [XLEN-1:0]  rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i,
           dp_done_i, dp_result_i, rsp_ready_i,
    output req_ready_o, dp_op_o, dp_a_o, dp_b_o, dp_start_o, dp_abort_o,
           rsp_valid_o, rsp_result_o, rsp_tag_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i,
           dp_done_i, dp_result_i, rsp_ready_i,
    input  req_ready_o, dp_op_o, dp_a_o, dp_b_o, dp_start_o, dp_abort_o,
           rsp_valid_o, rsp_result_o, rsp_tag_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/m_unit_ctrl.sv
// ============================================================================
// Module : m_unit_ctrl
// Brief  : Sequencer for the multiply/divide datapath; optional divide result
//          cache enabled by M_UNIT_CTRL_RESULT_CACHE_EN
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_unit_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  m_unit_ctrl_if.slave bus
);
  import m_unit_ctrl_pkg::*;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_RESP = 2'd3} state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_op;
  logic [XLEN-1:0]  r_a, r_b, r_result, w_hit_result;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_cnt;
  logic             r_first;
  logic             w_accept, w_capture, w_start, w_abort, w_hit;
  logic             w_req_mul, w_req_div, w_cur_mul, w_cur_w, w_zero_div;

  assign w_req_mul  = bus.req_op_i inside {ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU,
                                           ALU_OP_MULHU, ALU_OP_MULW};
  assign w_req_div  = bus.req_op_i inside {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
                                           ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};
  assign w_cur_mul  = (r_state == S_MUL);
  assign w_cur_w    = r_op inside {ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};
  assign w_zero_div = w_cur_w ? (r_b[31:0] == 32'd0) : (r_b == '0);

`ifdef M_UNIT_CTRL_RESULT_CACHE_EN
  logic            r_c_valid;
  logic [5:0]      r_c_op;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_res;

  assign w_hit        = r_c_valid && (r_c_op == bus.req_op_i) &&
                        (r_c_a == bus.req_a_i) && (r_c_b == bus.req_b_i);
  assign w_hit_result = r_c_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c_valid <= 1'b0;
      r_c_op    <= '0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_res   <= '0;
    end else if (bus.flush_i) begin
      r_c_valid <= 1'b0;
    end else if (w_capture && (r_state == S_DIV)) begin
      r_c_valid <= 1'b1;
      r_c_op    <= r_op;
      r_c_a     <= r_a;
      r_c_b     <= r_b;
      r_c_res   <= bus.dp_result_i;
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_hit_result = '0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_start   = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i && !bus.flush_i) begin
          w_accept = 1'b1;
          if (w_req_mul)      w_next = S_MUL;
          else if (w_req_div) w_next = w_hit ? S_RESP : S_DIV;
          else                w_next = S_RESP;
        end
      end
      S_MUL: begin
        // The start pulse also marks the first multiply cycle for the datapath.
        w_start = r_first;
        if (r_cnt == 4'd1) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_DIV: begin
        if (r_first) begin
          if (w_zero_div) begin
            w_capture = 1'b1;
            w_next    = S_RESP;
          end else begin
            w_start = 1'b1;
          end
        end else if (bus.dp_done_i) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush_i) begin
      w_next    = S_IDLE;
      w_capture = 1'b0;
      w_start   = 1'b0;
      w_abort   = (r_state == S_DIV);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
    end else begin
      r_first <= w_accept;
      if (w_accept) begin
        r_op  <= bus.req_op_i;
        r_a   <= bus.req_a_i;
        r_b   <= bus.req_b_i;
        r_tag <= bus.req_tag_i;
        r_cnt <= 4'(MUL_LAT);
        if (!w_req_mul && !w_req_div) r_result <= '0;
        else if (w_req_div && w_hit)  r_result <= w_hit_result;
      end else if (w_cur_mul) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) r_result <= bus.dp_result_i;
    end
  end

  assign bus.req_ready_o  = (r_state == S_IDLE) && !bus.flush_i;
  assign bus.rsp_valid_o  = (r_state == S_RESP) && !bus.flush_i;
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_tag_o    = r_tag;
  assign bus.dp_op_o      = r_op;
  assign bus.dp_a_o       = r_a;
  assign bus.dp_b_o       = r_b;
  assign bus.dp_start_o   = w_start;
  assign bus.dp_abort_o   = w_abort;
  assign bus.busy_o       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_m_unit_ctrl.sv
// ============================================================================
// Module : tb_m_unit_ctrl
// Brief  : Directed plus randomized bench for m_unit_ctrl with an arithmetic reference model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_unit_ctrl;
  import m_unit_ctrl_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dp_res_ok = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference cache state: last completed divide-class key
  logic        mc_valid = 1'b0;
  logic [5:0]  mc_op = '0;
  logic [63:0] mc_a = '0, mc_b = '0;

  always #5 clk = ~clk;

  m_unit_ctrl_if #(.TAG_W(TAG_W)) bus();

  m_unit_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [63:0] ref_res(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    p   = '0;
    case (op)
      ALU_OP_MUL:    return a * b;
      ALU_OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      ALU_OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      ALU_OP_MULHU:  begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      ALU_OP_MULW:   begin r32 = a32 * b32; return {{32{r32[31]}}, r32}; end
      ALU_OP_DIV: begin
        if (b == 64'd0) return {64{1'b1}};
        if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return a;
        return $signed(a) / $signed(b);
      end
      ALU_OP_DIVU: begin
        if (b == 64'd0) return {64{1'b1}};
        return a / b;
      end
      ALU_OP_REM: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 64'd0;
        return $signed(a) % $signed(b);
      end
      ALU_OP_REMU: begin
        if (b == 64'd0) return a;
        return a % b;
      end
      ALU_OP_DIVW: begin
        if (b32 == 32'd0) r32 = {32{1'b1}};
        else if (a32 == 32'h8000_0000 && b32 == {32{1'b1}}) r32 = a32;
        else r32 = $signed(a32) / $signed(b32);
        return {{32{r32[31]}}, r32};
      end
      ALU_OP_DIVUW: begin
        if (b32 == 32'd0) r32 = {32{1'b1}};
        else r32 = a32 / b32;
        return {{32{r32[31]}}, r32};
      end
      ALU_OP_REMW: begin
        if (b32 == 32'd0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == {32{1'b1}}) r32 = 32'd0;
        else r32 = $signed(a32) % $signed(b32);
        return {{32{r32[31]}}, r32};
      end
      ALU_OP_REMUW: begin
        if (b32 == 32'd0) r32 = a32;
        else r32 = a32 % b32;
        return {{32{r32[31]}}, r32};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Datapath stand-in: the result is only meaningful in the cycle it is due.
  always_comb begin
    bus.dp_result_i = dp_res_ok ? ref_res(bus.dp_op_o, bus.dp_a_o, bus.dp_b_o)
                                : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, input int done_at, input bit early_done,
                        input int stall);
    bit          is_mul, is_div, wform, zero, hit;
    int          exp_lat, res_cyc, cyc, starts, start_cyc, aborts, w;
    logic [63:0] exp_res;
    is_mul  = op inside {ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU, ALU_OP_MULW};
    is_div  = op inside {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
                         ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};
    wform   = op inside {ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW};
    zero    = wform ? (b[31:0] == 32'd0) : (b == 64'd0);
    hit     = 1'b0;
`ifdef M_UNIT_CTRL_RESULT_CACHE_EN
    hit     = is_div && mc_valid && mc_op == op && mc_a == a && mc_b == b;
`endif
    exp_res = ref_res(op, a, b);
    if (is_mul)      begin exp_lat = MUL_LAT + 1; res_cyc = MUL_LAT; end
    else if (!is_div || hit) begin exp_lat = 1;   res_cyc = -1; end
    else if (zero)   begin exp_lat = 2;           res_cyc = 1; end
    else             begin exp_lat = done_at + 1; res_cyc = done_at; end

    w = 0;
    while (!bus.req_ready_o && w < 50) begin @(negedge clk); w++; end
    chk("req_ready_before_accept", {63'd0, bus.req_ready_o}, 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    cyc = 1; starts = 0; start_cyc = 0; aborts = 0;
    while (cyc < 300) begin
      if (bus.dp_start_o) begin starts++; start_cyc = cyc; end
      if (bus.dp_abort_o) aborts++;
      if (bus.rsp_valid_o) break;
      bus.dp_done_i = is_div && (cyc == done_at || (early_done && cyc == 1));
      dp_res_ok     = (cyc == res_cyc);
      @(negedge clk);
      cyc++;
    end
    bus.dp_done_i = 1'b0;
    dp_res_ok     = 1'b0;
    chk("rsp_latency", 64'(cyc), 64'(exp_lat));
    chk("start_count", 64'(starts), (is_mul || (is_div && !hit && !zero)) ? 64'd1 : 64'd0);
    if (starts != 0) chk("start_cycle", 64'(start_cyc), 64'd1);
    chk("no_abort", 64'(aborts), 64'd0);
    chk("rsp_result", bus.rsp_result_o, exp_res);
    chk("rsp_tag", 64'(bus.rsp_tag_o), 64'(tag));

    if (stall > 0) begin
      bus.rsp_ready_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = ALU_OP_MUL;
        bus.req_a_i     = ~a;
        @(negedge clk);
        chk("stall_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        chk("stall_result", bus.rsp_result_o, exp_res);
        chk("stall_tag", 64'(bus.rsp_tag_o), 64'(tag));
        chk("stall_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
      end
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
    end
    @(negedge clk);
    chk("post_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("post_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("dp_a_hold", bus.dp_a_o, a);
    if (is_div) begin mc_valid = 1'b1; mc_op = op; mc_a = a; mc_b = b; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops [15];
    logic [5:0]  op;
    logic [63:0] a, b;
    int          cyc;
    ops = '{ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU, ALU_OP_MULW,
            ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
            ALU_OP_DIVW, ALU_OP_DIVUW, ALU_OP_REMW, ALU_OP_REMUW, 6'h05, 6'h3F};
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_tag_i   = '0;
    bus.flush_i     = 1'b0;
    bus.dp_done_i   = 1'b0;
    bus.rsp_ready_i = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("rst_dp_start", {63'd0, bus.dp_start_o}, 64'd0);
    chk("rst_dp_op", 64'(bus.dp_op_o), 64'd0);
    chk("rst_dp_a", bus.dp_a_o, 64'd0);
    chk("rst_result", bus.rsp_result_o, 64'd0);
    chk("rst_tag", 64'(bus.rsp_tag_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(ALU_OP_MUL, 64'd7, 64'd6, 5'd3, 0, 1'b0, 0);
    chk("mul_42", bus.rsp_result_o, 64'd42);
    run_op(ALU_OP_DIVU, 64'd100, 64'd7, 5'd9, 65, 1'b1, 0);
    chk("divu_14", bus.rsp_result_o, 64'd14);
    run_op(ALU_OP_DIVW, 64'd5, 64'h1_0000_0000, 5'd4, 6, 1'b0, 0);
    run_op(ALU_OP_REM, 64'd77, 64'd0, 5'd5, 6, 1'b0, 0);
    run_op(ALU_OP_MULHU, 64'hFFFF_0000_1234_5678, 64'h0000_FFFF_8765_4321, 5'd17, 0, 1'b0, 5);
    run_op(6'h05, 64'd1, 64'd2, 5'd21, 0, 1'b0, 2);

    // Flush in the tenth cycle of a divide, with a competing request
    bus.req_valid_i = 1'b1; bus.req_op_i = ALU_OP_DIVU;
    bus.req_a_i = 64'd1000; bus.req_b_i = 64'd3; bus.req_tag_i = 5'd11;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    bus.flush_i = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_op_i = ALU_OP_MUL; bus.req_a_i = 64'd55;
    #1;
    chk("flush_abort", {63'd0, bus.dp_abort_o}, 64'd1);
    chk("flush_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
    chk("flush_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    chk("flush_idle", {63'd0, bus.busy_o}, 64'd0);
    chk("flush_abort_once", {63'd0, bus.dp_abort_o}, 64'd0);
    chk("flush_req_dropped", bus.dp_a_o, 64'd1000);
    chk("flush_op_kept", 64'(bus.dp_op_o), 64'(ALU_OP_DIVU));
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
    end
    mc_valid = 1'b0;

    // Repeated divide, then a flush in IDLE before the same divide again
    run_op(ALU_OP_DIV, -64'sd20, 64'd3, 5'd1, 5, 1'b0, 0);
    chk("div_neg6", bus.rsp_result_o, -64'sd6);
    run_op(ALU_OP_DIV, -64'sd20, 64'd3, 5'd2, 5, 1'b0, 0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    mc_valid = 1'b0;
    run_op(ALU_OP_DIV, -64'sd20, 64'd3, 5'd3, 4, 1'b0, 0);

    op = ALU_OP_MUL; a = '0; b = '0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        op = ops[$urandom_range(0, 14)];
        a  = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       b = 64'd0;
          1:       b = {$urandom, 32'd0};
          default: b = {$urandom, $urandom};
        endcase
      end
      run_op(op, a, b, 5'($urandom), $urandom_range(2, 10), 1'($urandom), $urandom_range(0, 3));
    end

    // Reset in the middle of a divide
    bus.req_valid_i = 1'b1; bus.req_op_i = ALU_OP_DIVU;
    bus.req_a_i = 64'd9; bus.req_b_i = 64'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_no_abort", {63'd0, bus.dp_abort_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_idle", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_mid_dp_a", bus.dp_a_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
